i8085_system: RTL and testbench

I8085_SYSTEM -- requirements
Module: i8085_system

---
 rtl/i8085_pkg.sv | 21 ++
 rtl/i8085_if.sv | 34 +++
 rtl/i8085_clkgen.sv | 47 ++++
 rtl/i8085_system.sv | 139 +++++++++++++
 tb/tb_i8085_system.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i8085_pkg.sv
// i8085_pkg -- shared types and constants for the i8085_system fetch model.
//   tstate_e : machine-cycle T-state encoding (also driven out on t_state)
//   OP_HLT   : opcode that parks the machine in THLT
//   S_FETCH / S_HALT : {S1,S0} status codes
package i8085_pkg;

    typedef enum logic [2:0] {
        TRST = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        TW   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        THLT = 3'd6
    } tstate_e;

    localparam logic [7:0] OP_HLT  = 8'h76;
    localparam logic [1:0] S_FETCH = 2'b11;
    localparam logic [1:0] S_HALT  = 2'b00;

endpackage

// File: rtl/i8085_if.sv
// i8085_if -- external memory bus of the i8085 fetch machine.
//   ready   : memory ready (slave -> master)
//   ad_in   : AD7..AD0 read data (slave -> master)
//   ale     : address latch enable
//   rd_n    : active-low read strobe
//   io_m    : 0 = memory cycle
//   s       : status {S1,S0}
//   addr_hi : A15..A8
//   ad_out  : AD7..AD0 drive value, qualified by ad_oe
//   ad_oe   : AD bus output enable
// master = CPU side, slave = memory / testbench side.
interface i8085_if;

    logic       ready;
    logic [7:0] ad_in;
    logic       ale;
    logic       rd_n;
    logic       io_m;
    logic [1:0] s;
    logic [7:0] addr_hi;
    logic [7:0] ad_out;
    logic       ad_oe;

    modport master (
        input  ready, ad_in,
        output ale, rd_n, io_m, s, addr_hi, ad_out, ad_oe
    );

    modport slave (
        output ready, ad_in,
        input  ale, rd_n, io_m, s, addr_hi, ad_out, ad_oe
    );

endinterface

// File: rtl/i8085_clkgen.sv
// i8085_clkgen -- clock divider and reset synchronizer.
//   x1        : crystal clock, all flops on its rising edge
//   reset     : asynchronous active-high reset
//   phi1/phi2 : divide-by-two phases (phi2 = ~phi1)
//   clk_out   : external clock, equal to phi2
//   tick      : one-x1-cycle enable marking the end of a T-state (div == 1)
//   reset_out : system reset, high immediately on reset and for
//               RESET_SYNC_STAGES ticks after reset is released
module i8085_clkgen #(
    parameter int RESET_SYNC_STAGES = 2
) (
    input  logic x1,
    input  logic reset,
    output logic phi1,
    output logic phi2,
    output logic clk_out,
    output logic tick,
    output logic reset_out
);

    logic                         div_q;
    logic [RESET_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge x1 or posedge reset) begin
        if (reset) begin
            div_q <= 1'b0;
        end else begin
            div_q <= ~div_q;
        end
    end

    // Ones shift out one position per tick; the MSB is the last to clear.
    always_ff @(posedge x1 or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else if (tick) begin
            sync_q <= sync_q << 1;
        end
    end

    assign tick      = div_q;
    assign phi1      = div_q;
    assign phi2      = ~div_q;
    assign clk_out   = ~div_q;
    assign reset_out = sync_q[RESET_SYNC_STAGES-1];

endmodule

// File: rtl/i8085_system.sv
// i8085_system -- opcode-fetch machine cycle of an 8085-style CPU.
// Repeatedly fetches opcodes from pc (T1..T4), halting on HLT (8'h76).
//   x1, reset : crystal clock, asynchronous active-high reset
//   x2        : complementary crystal pin, unused
//   bus       : memory bus (i8085_if.master)
//   phi1/phi2/clk_out/reset_out : clock generator outputs
//   ir        : last fetched opcode
//   t_state   : current T-state encoding (i8085_pkg::tstate_e)
// Build option: define WAIT_STATE_EN to honour bus.ready in T2/TW;
// without it ready is ignored and T2 always proceeds to T3.
// RESET_PC sets the address of the first fetch after reset.
module i8085_system
    import i8085_pkg::*;
#(
    parameter int          RESET_SYNC_STAGES = 2,
    parameter logic [15:0] RESET_PC          = 16'h0000
) (
    input  logic        x1,
    input  logic        reset,
    input  logic        x2,
    i8085_if.master     bus,
    output logic        phi1,
    output logic        phi2,
    output logic        clk_out,
    output logic        reset_out,
    output logic [7:0]  ir,
    output logic [2:0]  t_state
);

    logic        tick;
    tstate_e     state_q;
    logic [15:0] pc_q;
    logic [7:0]  ir_q;
    logic        ale_q;
    logic        rd_n_q;
    logic        ad_oe_q;
    logic [1:0]  s_q;
    logic        wait_req;
    logic        unused_x2;

    assign unused_x2 = x2;

    i8085_clkgen #(
        .RESET_SYNC_STAGES(RESET_SYNC_STAGES)
    ) u_clkgen (
        .x1        (x1),
        .reset     (reset),
        .phi1      (phi1),
        .phi2      (phi2),
        .clk_out   (clk_out),
        .tick      (tick),
        .reset_out (reset_out)
    );

`ifdef WAIT_STATE_EN
    assign wait_req = ~bus.ready;
`else
    logic unused_ready;
    assign unused_ready = bus.ready;
    assign wait_req     = 1'b0;
`endif

    // Bus strobes are registered together with the state, so each
    // transition loads the strobe values of the state being entered.
    always_ff @(posedge x1 or posedge reset) begin
        if (reset) begin
            state_q <= TRST;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            ale_q   <= 1'b0;
            rd_n_q  <= 1'b1;
            ad_oe_q <= 1'b0;
            s_q     <= S_HALT;
        end else if (tick) begin
            case (state_q)
                TRST: begin
                    if (!reset_out) begin
                        state_q <= T1;
                        ale_q   <= 1'b1;
                        ad_oe_q <= 1'b1;
                        rd_n_q  <= 1'b1;
                        s_q     <= S_FETCH;
                    end
                end
                T1: begin
                    state_q <= T2;
                    ale_q   <= 1'b0;
                    ad_oe_q <= 1'b0;
                    rd_n_q  <= 1'b0;
                end
                T2: begin
                    state_q <= wait_req ? TW : T3;
                end
                TW: begin
                    if (!wait_req) begin
                        state_q <= T3;
                    end
                end
                T3: begin
                    ir_q    <= bus.ad_in;
                    rd_n_q  <= 1'b1;
                    state_q <= T4;
                end
                T4: begin
                    pc_q <= pc_q + 16'd1;
                    if (ir_q == OP_HLT) begin
                        state_q <= THLT;
                        s_q     <= S_HALT;
                    end else begin
                        state_q <= T1;
                        ale_q   <= 1'b1;
                        ad_oe_q <= 1'b1;
                    end
                end
                THLT: begin
                    state_q <= THLT;
                end
                default: begin
                    state_q <= TRST;
                    ale_q   <= 1'b0;
                    rd_n_q  <= 1'b1;
                    ad_oe_q <= 1'b0;
                    s_q     <= S_HALT;
                end
            endcase
        end
    end

    assign bus.ale     = ale_q;
    assign bus.rd_n    = rd_n_q;
    assign bus.ad_oe   = ad_oe_q;
    assign bus.s       = s_q;
    assign bus.io_m    = 1'b0;
    assign bus.addr_hi = pc_q[15:8];
    assign bus.ad_out  = pc_q[7:0];
    assign ir          = ir_q;
    assign t_state     = state_q;

endmodule

// File: tb/tb_i8085_system.sv
// tb_i8085_system -- directed self-checking bench for i8085_system.
// A second instance starts at RESET_PC = 16'hFFFF to exercise pc wrap.
module tb_i8085_system;

    logic       x1 = 1'b0;
    logic       x2;
    logic       reset = 1'b1;
    logic       ready_tb = 1'b1;
    logic [7:0] ad_in_tb = 8'h00;

    logic       phi1, phi2, clk_out, reset_out;
    logic [7:0] ir;
    logic [2:0] t_state;

    logic       w_phi1, w_phi2, w_clk_out, w_reset_out;
    logic [7:0] w_ir;
    logic [2:0] w_t_state;

    int checks = 0;
    int failures = 0;

    i8085_if bus ();
    i8085_if bus_w ();

    assign bus.ready   = ready_tb;
    assign bus.ad_in   = ad_in_tb;
    assign bus_w.ready = ready_tb;
    assign bus_w.ad_in = ad_in_tb;
    assign x2 = ~x1;

    always #5 x1 = ~x1;

    i8085_system #(.RESET_SYNC_STAGES(2)) dut (
        .x1        (x1),
        .reset     (reset),
        .x2        (x2),
        .bus       (bus),
        .phi1      (phi1),
        .phi2      (phi2),
        .clk_out   (clk_out),
        .reset_out (reset_out),
        .ir        (ir),
        .t_state   (t_state)
    );

    i8085_system #(.RESET_SYNC_STAGES(2), .RESET_PC(16'hFFFF)) dut_wrap (
        .x1        (x1),
        .reset     (reset),
        .x2        (x2),
        .bus       (bus_w),
        .phi1      (w_phi1),
        .phi2      (w_phi2),
        .clk_out   (w_clk_out),
        .reset_out (w_reset_out),
        .ir        (w_ir),
        .t_state   (w_t_state)
    );

    // One T-state = two x1 periods; sample 1 ns after the edge.
    task automatic tick();
        repeat (2) @(posedge x1);
        #1;
    endtask

    // Release lands on a falling x1 edge, so the second rising edge after
    // it is the first tick; returns 1 ns after that tick.
    task automatic apply_reset(input int hold);
        reset = 1'b1;
        repeat (hold) @(negedge x1);
        reset = 1'b0;
        @(posedge x1);
        @(posedge x1);
        #1;
    endtask

    task automatic to_first_t1();
        apply_reset(4);
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (30) @(negedge x1);
        #1;
        checks++;
        if ({phi1, phi2, clk_out, reset_out} !== 4'b0111) begin
            failures++;
            $display("FAIL reset_clocks: got %b expected 0111", {phi1, phi2, clk_out, reset_out});
        end
        checks++;
        if ({bus.ale, bus.rd_n, bus.ad_oe, bus.s, bus.io_m} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_bus: got %b expected 010000", {bus.ale, bus.rd_n, bus.ad_oe, bus.s, bus.io_m});
        end
        checks++;
        if ({t_state, ir, bus.addr_hi, bus.ad_out} !== 27'd0) begin
            failures++;
            $display("FAIL reset_state: t=%0d ir=%h addr=%h expected 0/00/0000", t_state, ir, {bus.addr_hi, bus.ad_out});
        end
        repeat (26) @(negedge x1);
        reset = 1'b0;
        @(posedge x1);
        #1;
        checks++;
        if ({phi1, phi2, clk_out, reset_out} !== 4'b1001) begin
            failures++;
            $display("FAIL phase_high: got %b expected 1001", {phi1, phi2, clk_out, reset_out});
        end
        @(posedge x1);
        #1;
        checks++;
        if ({phi1, phi2, clk_out, reset_out, t_state} !== 7'b0111_000) begin
            failures++;
            $display("FAIL after_tick1: got %b expected 0111000", {phi1, phi2, clk_out, reset_out, t_state});
        end
        tick();
        checks++;
        if ({reset_out, t_state} !== 4'b0_000) begin
            failures++;
            $display("FAIL after_tick2: reset_out=%b t=%0d expected 0/0", reset_out, t_state);
        end
        tick();
        checks++;
        if (t_state !== 3'd1 || {bus.addr_hi, bus.ad_out} !== 16'h0000) begin
            failures++;
            $display("FAIL first_t1: t=%0d addr=%h expected 1/0000", t_state, {bus.addr_hi, bus.ad_out});
        end
        $display("test_reset done at %0t", $time);
    endtask

    task automatic test_fetch();
        ad_in_tb = 8'h00;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (t_state !== 3'd1 || {bus.addr_hi, bus.ad_out} !== 16'(k)
                || {bus.ale, bus.rd_n, bus.ad_oe, bus.s} !== 5'b11111) begin
                failures++;
                $display("FAIL fetch%0d_t1: t=%0d addr=%h ctl=%b expected 1/%h/11111",
                         k, t_state, {bus.addr_hi, bus.ad_out}, {bus.ale, bus.rd_n, bus.ad_oe, bus.s}, 16'(k));
            end
            tick();
            checks++;
            if (t_state !== 3'd2 || {bus.ale, bus.rd_n, bus.ad_oe, bus.s} !== 5'b00011
                || {bus.addr_hi, bus.ad_out} !== 16'(k)) begin
                failures++;
                $display("FAIL fetch%0d_t2: t=%0d ctl=%b addr=%h expected 2/00011/%h",
                         k, t_state, {bus.ale, bus.rd_n, bus.ad_oe, bus.s}, {bus.addr_hi, bus.ad_out}, 16'(k));
            end
            tick();
            checks++;
            if (t_state !== 3'd4 || {bus.ale, bus.rd_n, bus.ad_oe, bus.s} !== 5'b00011) begin
                failures++;
                $display("FAIL fetch%0d_t3: t=%0d ctl=%b expected 4/00011",
                         k, t_state, {bus.ale, bus.rd_n, bus.ad_oe, bus.s});
            end
            tick();
            checks++;
            if (t_state !== 3'd5 || {bus.ale, bus.rd_n, bus.ad_oe, bus.s} !== 5'b01011 || ir !== 8'h00) begin
                failures++;
                $display("FAIL fetch%0d_t4: t=%0d ctl=%b ir=%h expected 5/01011/00",
                         k, t_state, {bus.ale, bus.rd_n, bus.ad_oe, bus.s}, ir);
            end
            tick();
            $display("fetch %0d addr=%h ir=%h", k, 16'(k), ir);
        end
        checks++;
        if (t_state !== 3'd1 || {bus.addr_hi, bus.ad_out} !== 16'h0003) begin
            failures++;
            $display("FAIL fetch3_t1: t=%0d addr=%h expected 1/0003", t_state, {bus.addr_hi, bus.ad_out});
        end
    endtask

    task automatic test_pc_wrap();
        ad_in_tb = 8'h00;
        to_first_t1();
        checks++;
        if (w_t_state !== 3'd1 || {bus_w.addr_hi, bus_w.ad_out} !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_start: t=%0d addr=%h expected 1/FFFF", w_t_state, {bus_w.addr_hi, bus_w.ad_out});
        end
        repeat (4) tick();
        checks++;
        if (w_t_state !== 3'd1 || {bus_w.addr_hi, bus_w.ad_out} !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_next: t=%0d addr=%h expected 1/0000", w_t_state, {bus_w.addr_hi, bus_w.ad_out});
        end
        checks++;
        if ({bus.addr_hi, bus.ad_out} !== 16'h0001) begin
            failures++;
            $display("FAIL wrap_main_pc: addr=%h expected 0001", {bus.addr_hi, bus.ad_out});
        end
        $display("pc wrap FFFF -> %h", {bus_w.addr_hi, bus_w.ad_out});
    endtask

    task automatic test_halt();
        int bad;
        bad = 0;
        ad_in_tb = 8'h00;
        to_first_t1();
        repeat (8) tick();
        ad_in_tb = 8'h76;
        tick();
        tick();
        tick();
        checks++;
        if (t_state !== 3'd5 || ir !== 8'h76) begin
            failures++;
            $display("FAIL halt_t4: t=%0d ir=%h expected 5/76", t_state, ir);
        end
        ad_in_tb = 8'h00;
        tick();
        checks++;
        if (t_state !== 3'd6 || {bus.ale, bus.rd_n, bus.ad_oe, bus.s} !== 5'b01000
            || {bus.addr_hi, bus.ad_out} !== 16'h0003) begin
            failures++;
            $display("FAIL halt_enter: t=%0d ctl=%b addr=%h expected 6/01000/0003",
                     t_state, {bus.ale, bus.rd_n, bus.ad_oe, bus.s}, {bus.addr_hi, bus.ad_out});
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (t_state !== 3'd6 || bus.s !== 2'b00 || {bus.addr_hi, bus.ad_out} !== 16'h0003) begin
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL halt_hold: ticks out of THLT got %0d expected 0", bad);
        end
        $display("halt at pc=%h ir=%h", {bus.addr_hi, bus.ad_out}, ir);
    endtask

    task automatic test_ready();
        to_first_t1();
        ready_tb = 1'b0;
        ad_in_tb = 8'h3C;
        tick();
        checks++;
        if (t_state !== 3'd2) begin
            failures++;
            $display("FAIL ready_t2: t=%0d expected 2", t_state);
        end
`ifdef WAIT_STATE_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (t_state !== 3'd3 || {bus.ale, bus.rd_n, bus.ad_oe, bus.s} !== 5'b00011) begin
                failures++;
                $display("FAIL ready_tw%0d: t=%0d ctl=%b expected 3/00011",
                         i, t_state, {bus.ale, bus.rd_n, bus.ad_oe, bus.s});
            end
        end
        ready_tb = 1'b1;
`endif
        tick();
        checks++;
        if (t_state !== 3'd4 || ir !== 8'h00) begin
            failures++;
            $display("FAIL ready_t3: t=%0d ir=%h expected 4/00", t_state, ir);
        end
        tick();
        checks++;
        if (t_state !== 3'd5 || ir !== 8'h3C) begin
            failures++;
            $display("FAIL ready_t4: t=%0d ir=%h expected 5/3C", t_state, ir);
        end
        ready_tb = 1'b1;
        $display("ready fetch ir=%h", ir);
    endtask

    task automatic test_reset_midcycle();
        ad_in_tb = 8'h00;
        to_first_t1();
        repeat (4) tick();
        ad_in_tb = 8'h5A;
        tick();
        tick();
        checks++;
        if (t_state !== 3'd4 || {bus.addr_hi, bus.ad_out} !== 16'h0001) begin
            failures++;
            $display("FAIL mid_t3: t=%0d addr=%h expected 4/0001", t_state, {bus.addr_hi, bus.ad_out});
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({t_state, bus.ale, bus.rd_n, bus.ad_oe, bus.s, reset_out, phi1} !== 10'b000_01000_10) begin
            failures++;
            $display("FAIL mid_reset_out: got %b expected 0000100010",
                     {t_state, bus.ale, bus.rd_n, bus.ad_oe, bus.s, reset_out, phi1});
        end
        checks++;
        if (ir !== 8'h00 || {bus.addr_hi, bus.ad_out} !== 16'h0000) begin
            failures++;
            $display("FAIL mid_reset_regs: ir=%h addr=%h expected 00/0000", ir, {bus.addr_hi, bus.ad_out});
        end
        ad_in_tb = 8'h00;
        apply_reset(3);
        tick();
        tick();
        checks++;
        if (t_state !== 3'd1 || {bus.addr_hi, bus.ad_out} !== 16'h0000 || ir !== 8'h00) begin
            failures++;
            $display("FAIL mid_restart: t=%0d addr=%h ir=%h expected 1/0000/00",
                     t_state, {bus.addr_hi, bus.ad_out}, ir);
        end
        $display("restart after mid-cycle reset addr=%h", {bus.addr_hi, bus.ad_out});
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_pc_wrap();
        test_halt();
        test_ready();
        test_reset_midcycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
